ft245_packetizer: RTL

//  Packs FFT output words {header, bin index, re, im} into fixed-length byte packets.

---
 rtl/ft245_packetizer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ft245_packetizer.sv
// ft245_packetizer: buffers {bin index, re, im} words and streams them as {header, index, re, im, pad}
// MSB-first byte packets over the FT2232H 245 synchronous FIFO write port. Define FT245_PACKETIZER_CHECKSUM_EN to append an XOR trailer byte.
module ft245_packetizer #(
    parameter int                   USB_DATA_WIDTH = 8,
    parameter int                   HDR_WIDTH      = 4,
    parameter logic [HDR_WIDTH-1:0] HDR_VALUE      = 4'hF,
    parameter int                   CTR_WIDTH      = 10,
    parameter int                   SAMPLE_WIDTH   = 25,
    parameter int                   FIFO_DEPTH     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [CTR_WIDTH-1:0]      s_ctr_i,
    input  logic [SAMPLE_WIDTH-1:0]   s_re_i,
    input  logic [SAMPLE_WIDTH-1:0]   s_im_i,
    input  logic                      ft_txe_n_i,
    output logic                      ft_wr_n_o,
    output logic [USB_DATA_WIDTH-1:0] ft_data_o,
    output logic                      overflow_o,
    output logic                      busy_o
);

    localparam int DATA_BITS  = CTR_WIDTH + 2 * SAMPLE_WIDTH;
    localparam int PKT_BITS   = HDR_WIDTH + DATA_BITS;
    localparam int PKT_BYTES  = (PKT_BITS + USB_DATA_WIDTH - 1) / USB_DATA_WIDTH;
    localparam int FRAME_BITS = PKT_BYTES * USB_DATA_WIDTH;
    localparam int IDX_W      = $clog2(PKT_BYTES + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
`ifdef FT245_PACKETIZER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [DATA_BITS-1:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]          count_r, count_nxt_s;
    logic                      ready_r, overflow_r, busy_r;
    logic                      wr_s, pop_s, empty_s, consume_s;
    logic [DATA_BITS-1:0]      head_s;
    logic [0:0]                state_r, state_nxt_s;
    logic [IDX_W-1:0]          idx_r, idx_nxt_s;
    logic [FRAME_BITS-1:0]     frame_r, frame_nxt_s;
    logic                      wr_n_r, wr_n_nxt_s;
    logic [USB_DATA_WIDTH-1:0] data_r, data_nxt_s;

    // Header goes in the MSBs; any bits left over in the final byte are zero.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_BITS-1:0] d);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1 -: PKT_BITS] = {HDR_VALUE, d};
        return f;
    endfunction

`ifdef FT245_PACKETIZER_CHECKSUM_EN
    function automatic logic [USB_DATA_WIDTH-1:0] xor_bytes(input logic [FRAME_BITS-1:0] f);
        logic [USB_DATA_WIDTH-1:0] x;
        x = '0;
        for (int k = 0; k < PKT_BYTES; k++) begin
            x = x ^ f[k*USB_DATA_WIDTH +: USB_DATA_WIDTH];
        end
        return x;
    endfunction
`endif

    function automatic logic [USB_DATA_WIDTH-1:0] frame_byte(input logic [FRAME_BITS-1:0] f,
                                                             input logic [IDX_W-1:0] idx);
        logic [USB_DATA_WIDTH-1:0] b;
        b = '0;
        for (int k = 0; k < PKT_BYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                b = f[(PKT_BYTES-1-k)*USB_DATA_WIDTH +: USB_DATA_WIDTH];
            end
        end
`ifdef FT245_PACKETIZER_CHECKSUM_EN
        if (idx == IDX_W'(PKT_BYTES)) begin
            b = xor_bytes(f);
        end
`endif
        return b;
    endfunction

    assign empty_s     = (count_r == '0);
    assign head_s      = mem_r[rd_ptr_r];
    assign wr_s        = s_valid_i && ready_r;
    assign consume_s   = !wr_n_r && !ft_txe_n_i;
    assign count_nxt_s = count_r + CNT_W'(wr_s) - CNT_W'(pop_s);

    // Packet sequencer: loads a word, presents one byte per consume, chains packets without a gap.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        frame_nxt_s = frame_r;
        wr_n_nxt_s  = wr_n_r;
        data_nxt_s  = data_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    frame_nxt_s = make_frame(head_s);
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_SEND;
                end else begin
                    wr_n_nxt_s  = 1'b1;
                end
            end
            ST_SEND: begin
                // wr_n still high here means the frame was just loaded and byte 0 is not yet shown.
                if (wr_n_r) begin
                    wr_n_nxt_s = 1'b0;
                    data_nxt_s = frame_byte(frame_r, idx_r);
                end else if (consume_s) begin
                    if (idx_r != LAST_IDX) begin
                        idx_nxt_s  = idx_r + IDX_W'(1);
                        data_nxt_s = frame_byte(frame_r, idx_r + IDX_W'(1));
                    end else if (!empty_s) begin
                        pop_s       = 1'b1;
                        frame_nxt_s = make_frame(head_s);
                        idx_nxt_s   = '0;
                        data_nxt_s  = frame_byte(make_frame(head_s), '0);
                    end else begin
                        state_nxt_s = ST_IDLE;
                        wr_n_nxt_s  = 1'b1;
                    end
                end else begin
                    wr_n_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wr_n_nxt_s  = 1'b1;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            frame_r <= '0;
            wr_n_r  <= 1'b1;
            data_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            frame_r <= frame_nxt_s;
            wr_n_r  <= wr_n_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {s_ctr_i, s_re_i, s_im_i};
        end
    end

    // FIFO pointers, occupancy and the registered status flags.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ready_r    <= 1'b1;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nxt_s;
            ready_r    <= (count_nxt_s != CNT_W'(FIFO_DEPTH));
            overflow_r <= overflow_r | (s_valid_i & ~ready_r);
            busy_r     <= (state_nxt_s != ST_IDLE) || (count_nxt_s != '0);
        end
    end

    assign s_ready_o  = ready_r;
    assign ft_wr_n_o  = wr_n_r;
    assign ft_data_o  = data_r;
    assign overflow_o = overflow_r;
    assign busy_o     = busy_r;

endmodule
